// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the Nios II multiply unit.
package nios2_mult_pkg;

  localparam int unsigned MULT_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXSS = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXUU = 2'd3
  } mult_op_e;

  // True for the ops that return the upper half of the product.
  function automatic logic is_high_op(input mult_op_e op);
    return op != OP_MUL;
  endfunction

endpackage

// File: rtl/nios2_mult_lane.sv
// One registered LANE_W x LANE_W unsigned multiplier (one DSP block).
module nios2_mult_lane #(
  parameter int unsigned LANE_W = 16
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [LANE_W-1:0]   a_i,
  input  logic [LANE_W-1:0]   b_i,
  output logic [2*LANE_W-1:0] p_o
);

  logic [2*LANE_W-1:0] p_q;

  // Capture the full-width product when enabled; clear wins.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= {{LANE_W{1'b0}}, a_i} * {{LANE_W{1'b0}}, b_i};
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/nios2_mult_unit.sv
// Two-stage pipelined multiplier covering mul/mulxss/mulxsu/mulxuu.
module nios2_mult_unit
  import nios2_mult_pkg::*;
#(
  parameter int unsigned DATA_W = MULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int unsigned LANE_W = DATA_W / 2;

  mult_op_e          op_in;
  logic              accept;
  logic              s2_advance;

  logic              s1_valid_q;
  mult_op_e          s1_op_q;
  logic              s1_sa_q;
  logic              s1_sb_q;
  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] s1_b_q;

  logic [DATA_W-1:0] pp_ll;
  logic [DATA_W-1:0] pp_lh;
  logic [DATA_W-1:0] pp_hl;
  logic [DATA_W-1:0] pp_hh;

  logic [DATA_W:0]     mid;
  logic [2*DATA_W-1:0] ll_x;
  logic [2*DATA_W-1:0] mid_x;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   result_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q;

  assign op_in      = mult_op_e'(in_op);
  assign s2_advance = ~out_valid_q | out_ready;
  assign in_ready   = ~reset & ~flush & (~s1_valid_q | s2_advance);
  assign accept     = in_valid & in_ready;

  nios2_mult_lane #(.LANE_W(LANE_W)) u_lane_ll (
    .clk_i(clk), .clr_i(reset), .en_i(accept),
    .a_i(in_src1[LANE_W-1:0]), .b_i(in_src2[LANE_W-1:0]), .p_o(pp_ll)
  );

  nios2_mult_lane #(.LANE_W(LANE_W)) u_lane_lh (
    .clk_i(clk), .clr_i(reset), .en_i(accept),
    .a_i(in_src1[LANE_W-1:0]), .b_i(in_src2[DATA_W-1:LANE_W]), .p_o(pp_lh)
  );

  nios2_mult_lane #(.LANE_W(LANE_W)) u_lane_hl (
    .clk_i(clk), .clr_i(reset), .en_i(accept),
    .a_i(in_src1[DATA_W-1:LANE_W]), .b_i(in_src2[LANE_W-1:0]), .p_o(pp_hl)
  );

  nios2_mult_lane #(.LANE_W(LANE_W)) u_lane_hh (
    .clk_i(clk), .clr_i(reset), .en_i(accept),
    .a_i(in_src1[DATA_W-1:LANE_W]), .b_i(in_src2[DATA_W-1:LANE_W]), .p_o(pp_hh)
  );

  // S1 side-band: op, sign flags and raw operands for the correction step.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_MUL;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= accept | (s1_valid_q & ~s2_advance);
      end
      if (accept) begin
        s1_op_q <= op_in;
        s1_sa_q <= in_src1[DATA_W-1] & ((op_in == OP_MULXSS) | (op_in == OP_MULXSU));
        s1_sb_q <= in_src2[DATA_W-1] & (op_in == OP_MULXSS);
        s1_a_q  <= in_src1;
        s1_b_q  <= in_src2;
      end
    end
  end

  // Recombine partial products, apply signed correction, pick the half.
  always_comb begin
    mid   = {1'b0, pp_lh} + {1'b0, pp_hl};
    ll_x  = '0;
    ll_x[DATA_W-1:0] = pp_ll;
    mid_x = '0;
    mid_x[LANE_W +: DATA_W+1] = mid;
    prod  = ll_x + mid_x + {pp_hh, {DATA_W{1'b0}}};
    if (s1_sa_q) begin
      prod = prod - {s1_b_q, {DATA_W{1'b0}}};
    end
    if (s1_sb_q) begin
      prod = prod - {s1_a_q, {DATA_W{1'b0}}};
    end
    result_d = is_high_op(s1_op_q) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
  end

  // S2 output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (s2_advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= result_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_nios2_mult_unit.sv
// Self-checking bench for nios2_mult_unit: directed literals plus random traffic.
module tb_nios2_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // Reference: two slots holding expected results, filled from plain 64-bit math.
  logic        m1v = 1'b0, m2v = 1'b0;
  logic [31:0] m1d = '0, m2d = '0;
  logic        mrdy;

  logic [31:0] got_q[$];
  int          got_cyc[$];

  nios2_mult_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  assign mrdy = !reset && !flush && (!m1v || !m2v || out_ready);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || flush) begin
      m1v <= 1'b0;
      m2v <= 1'b0;
      if (reset) m2d <= '0;
    end else begin
      if (!m2v || out_ready) begin
        m2v <= m1v;
        if (m1v) m2d <= m1d;
      end
      if (mrdy && in_valid) begin
        m1v <= 1'b1;
        m1d <= ref_mul(in_src1, in_src2, in_op);
      end else if (!m2v || out_ready) begin
        m1v <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the reference, plus capture of retired results.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, mrdy});
      check("out_valid", {31'b0, out_valid}, {31'b0, m2v});
      if (m2v) check("out_result", out_result, m2d);
    end
    if (!reset && out_valid === 1'b1 && out_ready) begin
      got_q.push_back(out_result);
      got_cyc.push_back(cyc);
    end
  end

  // Called at #1 after a rising edge; leaves in_valid high on return.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n;
    in_src1 = a; in_src2 = b; in_op = op; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic expect_get(input string name, input logic [31:0] exp, output int c);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      c = -1;
    end else begin
      check(name, got_q.pop_front(), exp);
      c = got_cyc.pop_front();
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c;
    logic [31:0] lit[4];
    logic [31:0] r;
    // Reset
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("ready_in_reset", {31'b0, in_ready}, 32'd0);
    cycles(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: result exactly two cycles after accept
    issue(32'h0000FFFF, 32'h0000FFFF, 2'd0);
    idle();
    @(posedge clk); #1;
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("lat_result", out_result, 32'hFFFE0001);
    cycles(3);
    got_q.delete(); got_cyc.delete();

    // Back-to-back ops on all-ones operands
    lit[0] = 32'h00000001; lit[1] = 32'hFFFFFFFE; lit[2] = 32'h00000000; lit[3] = 32'hFFFFFFFF;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2);
    idle();
    expect_get("b2b_0", lit[0], c0);
    for (int i = 1; i < 4; i++) begin
      expect_get($sformatf("b2b_%0d", i), lit[i], c);
      check($sformatf("b2b_gap_%0d", i), c, c0 + i);
    end
    cycles(2);
    got_q.delete(); got_cyc.delete();

    // Back-pressure: fill, stall 5 cycles, release with a new op entering
    out_ready = 1'b0;
    issue(32'h00010000, 32'h00010000, 2'd3);
    issue(32'h00010000, 32'h00010000, 2'd0);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", {31'b0, in_ready}, 32'd0);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_stable", out_result, 32'h00000001);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(32'h80000000, 32'h80000000, 2'd1);
    issue(32'h80000000, 32'h80000000, 2'd2);
    idle();
    expect_get("bp_first", 32'h00000001, c);
    expect_get("bp_second", 32'h00000000, c);
    expect_get("ss_min", 32'h40000000, c);
    expect_get("su_min", 32'hC0000000, c);
    cycles(4);
    check("bp_no_dup", got_q.size(), 32'd0);
    got_q.delete(); got_cyc.delete();

    // Flush with two in flight and a third offered
    out_ready = 1'b0;
    issue(32'h00000005, 32'h00000009, 2'd0);
    issue(32'h00000006, 32'h00000009, 2'd0);
    in_src1 = 32'h7; in_src2 = 32'h9; in_op = 2'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    issue(32'h00000003, 32'h00000007, 2'd0);
    idle();
    @(posedge clk); #1;
    check("post_flush_valid", {31'b0, out_valid}, 32'd1);
    check("post_flush_result", out_result, 32'h00000015);
    cycles(3);
    expect_get("post_flush_get", 32'h00000015, c);
    check("flush_killed", got_q.size(), 32'd0);
    got_q.delete(); got_cyc.delete();

    // Random traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: r = 32'h0;
          1: r = 32'hFFFFFFFF;
          2: r = 32'h80000000;
          3: r = 32'h7FFFFFFF;
          default: r = $urandom;
        endcase
        if (k == 0) in_src1 = r; else in_src2 = r;
      end
      in_op     = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
